// File: rtl/lift_controller.sv
// lift_controller: SCAN-policy multi-floor lift controller with per-floor travel and door dwell timers.
// Optional macro LIFT_EMERG_EN adds i_emerg_stop (stop at the next floor, drop all calls, hold the door).

module lift_controller #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_FLOORS-1:0]         i_call_req,
  input  logic                          i_door_hold,
`ifdef LIFT_EMERG_EN
  input  logic                          i_emerg_stop,
`endif
  output logic [$clog2(NUM_FLOORS)-1:0] o_cur_floor,
  output logic                          o_moving,
  output logic                          o_dir_up,
  output logic                          o_door_open,
  output logic [NUM_FLOORS-1:0]         o_pending
);

  localparam int unsigned FW = $clog2(NUM_FLOORS);
  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_DOOR   = 2'd2;

  logic [1:0]            r_state;
  logic [FW-1:0]         r_cur_floor;
  logic                  r_dir_up;
  logic [TW-1:0]         r_travel_tmr;
  logic [DW-1:0]         r_door_tmr;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_moving;
  logic                  r_door_open;

  logic [1:0]            w_state_nxt;
  logic [FW-1:0]         w_floor_nxt;
  logic                  w_dir_nxt;
  logic [TW-1:0]         w_travel_nxt;
  logic [DW-1:0]         w_door_nxt;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_calls;
  logic [NUM_FLOORS-1:0] w_clear_mask;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic [FW-1:0]         w_step_floor;
  logic                  w_at_end;
  logic                  w_estop_live;
  logic                  w_estop_stop;

`ifdef LIFT_EMERG_EN
  logic r_estop_latched;

  // Remember a stop request seen mid-segment until the car has reached the door
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_estop_latched <= 1'b0;
    end else if (r_state == S_MOVING) begin
      r_estop_latched <= r_estop_latched | i_emerg_stop;
    end else begin
      r_estop_latched <= 1'b0;
    end
  end

  assign w_estop_live = i_emerg_stop;
  assign w_estop_stop = i_emerg_stop | r_estop_latched;
`else
  assign w_estop_live = 1'b0;
  assign w_estop_stop = 1'b0;
`endif

  assign w_calls      = r_pending | i_call_req;
  assign w_step_floor = r_dir_up ? (r_cur_floor + FW'(1)) : (r_cur_floor - FW'(1));
  assign w_at_end     = r_dir_up ? (r_cur_floor == TOP_FLOOR) : (r_cur_floor == FW'(0));

  // Latched requests strictly above / below the car
  always_comb begin
    w_above = '0;
    w_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FW'(i) > r_cur_floor) w_above[i] = r_pending[i];
      if (FW'(i) < r_cur_floor) w_below[i] = r_pending[i];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_floor_nxt  = r_cur_floor;
    w_dir_nxt    = r_dir_up;
    w_travel_nxt = r_travel_tmr;
    w_door_nxt   = r_door_tmr;
    case (r_state)
      S_IDLE: begin
        if (r_pending[r_cur_floor]) begin
          w_state_nxt = S_DOOR;
          w_door_nxt  = DOOR_LOAD;
        end else if (r_pending != '0) begin
          w_dir_nxt    = (|w_above) && (r_dir_up || !(|w_below));
          w_travel_nxt = TRAVEL_LOAD;
          w_state_nxt  = S_MOVING;
        end
      end
      S_MOVING: begin
        if (r_travel_tmr != '0) begin
          w_travel_nxt = r_travel_tmr - TW'(1);
        end else if (w_at_end) begin
          // Defensive: never step past the shaft ends
          w_state_nxt = S_DOOR;
          w_door_nxt  = DOOR_LOAD;
        end else begin
          w_floor_nxt = w_step_floor;
          if (w_calls[w_step_floor] || w_estop_stop) begin
            w_state_nxt = S_DOOR;
            w_door_nxt  = DOOR_LOAD;
          end else begin
            w_travel_nxt = TRAVEL_LOAD;
          end
        end
      end
      S_DOOR: begin
        if (i_door_hold || i_call_req[r_cur_floor] || w_estop_live) begin
          w_door_nxt = DOOR_LOAD;
        end else if (r_door_tmr == '0) begin
          w_state_nxt = S_IDLE;
          if (r_cur_floor == FW'(0)) begin
            w_dir_nxt = 1'b1;
          end else if (r_cur_floor == TOP_FLOOR) begin
            w_dir_nxt = 1'b0;
          end
        end else begin
          w_door_nxt = r_door_tmr - DW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Calls at the floor whose door is (or is about to be) open are served, not latched
  assign w_clear_mask  = (w_state_nxt == S_DOOR) ? (NUM_FLOORS'(1) << w_floor_nxt) : '0;
  assign w_pending_nxt = w_estop_live ? '0 : (w_calls & ~w_clear_mask);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cur_floor  <= '0;
      r_dir_up     <= 1'b1;
      r_travel_tmr <= '0;
      r_door_tmr   <= '0;
      r_pending    <= '0;
      r_moving     <= 1'b0;
      r_door_open  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_floor  <= w_floor_nxt;
      r_dir_up     <= w_dir_nxt;
      r_travel_tmr <= w_travel_nxt;
      r_door_tmr   <= w_door_nxt;
      r_pending    <= w_pending_nxt;
      r_moving     <= (w_state_nxt == S_MOVING);
      r_door_open  <= (w_state_nxt == S_DOOR);
    end
  end

  assign o_cur_floor = r_cur_floor;
  assign o_moving    = r_moving;
  assign o_dir_up    = r_dir_up;
  assign o_door_open = r_door_open;
  assign o_pending   = r_pending;

endmodule

// File: tb/tb_lift_controller.sv
// tb_lift_controller: scenario-based bench for lift_controller (default 8-floor car plus a 4-floor car).
// Expected stop floors are queued when calls are placed and popped when a door opens.

module tb_lift_controller;

  localparam int K_OPEN    = 0;
  localparam int K_CLOSED  = 1;
  localparam int K_AT      = 2;
  localparam int K_OPEN4   = 3;
  localparam int K_CLOSED4 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] call_req;
  logic       door_hold;
  logic [2:0] cur_floor;
  logic       moving, dir_up, door_open;
  logic [7:0] pending;
`ifdef LIFT_EMERG_EN
  logic       emerg;
`endif

  logic [3:0] call4;
  logic [1:0] cur4;
  logic       moving4, dir4, door4;
  logic [3:0] pending4;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  lift_controller #(.NUM_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) u_dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_call_req  (call_req),
    .i_door_hold (door_hold),
`ifdef LIFT_EMERG_EN
    .i_emerg_stop(emerg),
`endif
    .o_cur_floor (cur_floor),
    .o_moving    (moving),
    .o_dir_up    (dir_up),
    .o_door_open (door_open),
    .o_pending   (pending)
  );

  lift_controller #(.NUM_FLOORS(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) u_dut4 (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_call_req  (call4),
    .i_door_hold (1'b0),
`ifdef LIFT_EMERG_EN
    .i_emerg_stop(1'b0),
`endif
    .o_cur_floor (cur4),
    .o_moving    (moving4),
    .o_dir_up    (dir4),
    .o_door_open (door4),
    .o_pending   (pending4)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input int kind, input int arg, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (kind)
        K_OPEN:   seen = door_open;
        K_CLOSED: seen = !door_open;
        K_AT:     seen = moving && (int'(cur_floor) == arg);
        K_OPEN4:  seen = door4;
        default:  seen = !door4;
      endcase
      if (seen) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    call_req = '0;
    door_hold = 1'b0;
    call4 = '0;
`ifdef LIFT_EMERG_EN
    emerg = 1'b0;
`endif
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    int active;
    do_reset();
    active = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (moving || door_open || cur_floor != 3'd0) active++;
    end
    n_cmp++;
    if (active !== 0) begin n_bad++; $display("FAIL reset_idle: active cycles %0d, want 0", active); end
    n_cmp++;
    if (dir_up !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %b want 1", dir_up); end
    n_cmp++;
    if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %h want 00", pending); end
  endtask

  task automatic test_reset_mid_motion();
    bit seen;
    do_reset();
    call_req = 8'h20;
    cyc(1);
    call_req = '0;
    wait_for(K_AT, 1, 40, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL midrst_reach: floor 1 not reached, cur %0d", cur_floor); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cur_floor, moving, dir_up, door_open, pending} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL midrst_outputs: floor %0d mov %b dir %b door %b pend %h, want 0 0 1 0 00",
               cur_floor, moving, dir_up, door_open, pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_call();
    int open_cnt;
    int want;
    do_reset();
    call_req = 8'h08;
    exp_q.push_back(3);
    cyc(1);
    call_req = '0;
    n_cmp++;
    if (pending !== 8'h08 || moving !== 1'b0) begin
      n_bad++; $display("FAIL single_latch: pend %h mov %b, want 08 0", pending, moving);
    end
    cyc(1);
    n_cmp++;
    if (moving !== 1'b1 || cur_floor !== 3'd0) begin
      n_bad++; $display("FAIL single_start: mov %b floor %0d, want 1 0", moving, cur_floor);
    end
    cyc(3);
    n_cmp++;
    if (cur_floor !== 3'd0) begin n_bad++; $display("FAIL single_f0_hold: floor %0d want 0", cur_floor); end
    cyc(1);
    n_cmp++;
    if (cur_floor !== 3'd1) begin n_bad++; $display("FAIL single_f1: floor %0d want 1", cur_floor); end
    cyc(4);
    n_cmp++;
    if (cur_floor !== 3'd2) begin n_bad++; $display("FAIL single_f2: floor %0d want 2", cur_floor); end
    cyc(4);
    want = exp_q.pop_front();
    n_cmp++;
    if (int'(cur_floor) != want || door_open !== 1'b1 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL single_arrive: floor %0d door %b mov %b, want %0d 1 0", cur_floor, door_open, moving, want);
    end
    n_cmp++;
    if (pending !== 8'h00) begin n_bad++; $display("FAIL single_cleared: pend %h want 00", pending); end
    open_cnt = 1;
    for (int i = 0; i < 40 && door_open; i++) begin
      cyc(1);
      if (door_open) open_cnt++;
    end
    n_cmp++;
    if (open_cnt !== 6) begin n_bad++; $display("FAIL single_dwell: open %0d cycles want 6", open_cnt); end
  endtask

  task automatic test_sweep();
    bit seen;
    int want;
    do_reset();
    call_req = 8'h20;
    exp_q.push_back(5);
    cyc(1);
    call_req = '0;
    wait_for(K_AT, 2, 40, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL sweep_reach2: floor %0d", cur_floor); end
    call_req = 8'h22;
    exp_q.push_back(1);
    cyc(1);
    call_req = '0;
    for (int s = 0; s < 2; s++) begin
      wait_for(K_OPEN, 0, 200, seen);
      want = exp_q.pop_front();
      n_cmp++;
      if (!seen || int'(cur_floor) != want) begin
        n_bad++; $display("FAIL sweep_stop%0d: floor %0d open %b, want %0d", s, cur_floor, seen, want);
      end
      n_cmp++;
      if (dir_up !== (s == 0)) begin
        n_bad++; $display("FAIL sweep_dir%0d: got %b want %b", s, dir_up, (s == 0));
      end
      wait_for(K_CLOSED, 0, 50, seen);
    end
    n_cmp++;
    if (pending !== 8'h00 || moving !== 1'b0) begin
      n_bad++; $display("FAIL sweep_done: pend %h mov %b, want 00 0", pending, moving);
    end
  endtask

  // Car sits idle at floor 1; open its door and extend the dwell with hold or a same-floor call.
  task automatic test_door_hold(input bit use_call);
    bit seen;
    int open_cnt;
    int latched;
    call_req = 8'h02;
    cyc(1);
    call_req = '0;
    wait_for(K_OPEN, 0, 10, seen);
    n_cmp++;
    if (!seen || cur_floor !== 3'd1) begin
      n_bad++; $display("FAIL hold%0d_open: open %b floor %0d, want 1 1", use_call, seen, cur_floor);
    end
    open_cnt = 1;
    latched = 0;
    if (use_call) call_req = 8'h02;
    else door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (door_open) open_cnt++;
      if (pending[1]) latched++;
    end
    call_req = '0;
    door_hold = 1'b0;
    for (int i = 0; i < 40 && door_open; i++) begin
      cyc(1);
      if (door_open) open_cnt++;
    end
    n_cmp++;
    if (open_cnt !== 16) begin
      n_bad++; $display("FAIL hold%0d_dwell: open %0d cycles want 16", use_call, open_cnt);
    end
    n_cmp++;
    if (latched !== 0) begin
      n_bad++; $display("FAIL hold%0d_latched: pending[1] set %0d cycles want 0", use_call, latched);
    end
    cyc(5);
    n_cmp++;
    if (moving !== 1'b0 || door_open !== 1'b0 || pending !== 8'h00) begin
      n_bad++; $display("FAIL hold%0d_idle: mov %b door %b pend %h, want 0 0 00", use_call, moving, door_open, pending);
    end
  endtask

  task automatic test_top_boundary();
    bit seen;
    int want;
    int seq[$];
    logic [1:0] last;
    int dir_bad;
    do_reset();
    call4 = 4'h8;
    exp_q.push_back(3);
    cyc(1);
    call4 = '0;
    wait_for(K_OPEN4, 0, 60, seen);
    want = exp_q.pop_front();
    n_cmp++;
    if (!seen || int'(cur4) != want) begin
      n_bad++; $display("FAIL top_arrive: floor %0d open %b, want %0d", cur4, seen, want);
    end
    wait_for(K_CLOSED4, 0, 20, seen);
    n_cmp++;
    if (dir4 !== 1'b0) begin n_bad++; $display("FAIL top_dir_forced: got %b want 0", dir4); end
    call4 = 4'h1;
    exp_q.push_back(0);
    cyc(1);
    call4 = '0;
    last = cur4;
    dir_bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc(1);
      if (cur4 != last) begin seq.push_back(int'(cur4)); last = cur4; end
      if (moving4 && dir4) dir_bad++;
      seen = door4;
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (!seen || int'(cur4) != want) begin
      n_bad++; $display("FAIL top_stop0: floor %0d open %b, want %0d", cur4, seen, want);
    end
    n_cmp++;
    if (seq.size() != 3 || seq[0] != 2 || seq[1] != 1 || seq[2] != 0) begin
      n_bad++; $display("FAIL top_path: %0d steps, got %p want 2 1 0", seq.size(), seq);
    end
    n_cmp++;
    if (dir_bad !== 0) begin n_bad++; $display("FAIL top_dir_moving: up while moving %0d cycles want 0", dir_bad); end
    wait_for(K_CLOSED4, 0, 20, seen);
    n_cmp++;
    if (dir4 !== 1'b1) begin n_bad++; $display("FAIL bottom_dir_forced: got %b want 1", dir4); end
  endtask

`ifdef LIFT_EMERG_EN
  task automatic test_emerg();
    bit seen;
    int closed_cnt;
    int n;
    int moved;
    do_reset();
    call_req = 8'hC0;
    cyc(1);
    call_req = '0;
    wait_for(K_AT, 2, 40, seen);
    cyc(1);
    emerg = 1'b1;
    wait_for(K_OPEN, 0, 10, seen);
    n_cmp++;
    if (!seen || cur_floor !== 3'd3 || pending !== 8'h00) begin
      n_bad++; $display("FAIL emerg_stop: open %b floor %0d pend %h, want 1 3 00", seen, cur_floor, pending);
    end
    closed_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!door_open) closed_cnt++;
    end
    n_cmp++;
    if (closed_cnt !== 0) begin n_bad++; $display("FAIL emerg_hold: closed %0d cycles want 0", closed_cnt); end
    emerg = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && door_open; i++) begin
      cyc(1);
      n++;
    end
    n_cmp++;
    if (n !== 6 || door_open !== 1'b0) begin
      n_bad++; $display("FAIL emerg_release: closed after %0d cycles want 6", n);
    end
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (moving || pending != 8'h00) moved++;
    end
    n_cmp++;
    if (moved !== 0) begin n_bad++; $display("FAIL emerg_idle: active %0d cycles want 0", moved); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_motion();
    test_single_call();
    test_sweep();
    test_door_hold(1'b0);
    test_door_hold(1'b1);
    test_top_boundary();
`ifdef LIFT_EMERG_EN
    test_emerg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lift_controller.md
Name: lift_controller

Overview:
- Parametrised multi-floor lift controller; successor to the two-state lift FSM.
- Latches floor call requests and serves them in the current direction of travel (SCAN policy).
- Models per-floor travel time and door dwell with internal counters.
- Drives floor position, motion and door status to the top-level display and motor logic.

Parameters:
- NUM_FLOORS, 8, number of floors (≥2); floors numbered 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (≥1).
- DOOR_CYCLES, 6, clock cycles the door stays open (≥1).
- Local FW = $clog2(NUM_FLOORS).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- call_req, input, NUM_FLOORS, one bit per floor; level or pulse, sampled every cycle.
- door_hold, input, 1, while high in DOOR, reloads the door timer.
- cur_floor, output, FW, current floor.
- moving, output, 1, high in MOVING.
- dir_up, output, 1, current direction (1 = up).
- door_open, output, 1, high in DOOR.
- pending, output, NUM_FLOORS, latched outstanding requests.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0, both timers=0.
- Request latching:
  - Every edge: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask has the cur_floor bit set on entry to DOOR and throughout DOOR. A call at the current floor while in DOOR is never latched.
  - It instead reloads the door timer, same as door_hold.
- States: IDLE, MOVING, DOOR. All outputs are registered.
- IDLE:
  - pending==0: stay.
  - pending[cur_floor]: go to DOOR next edge.
  - Otherwise choose direction:
    - up if a request exists above and (dir_up, or none exists below);
    - else down.
  - Set dir_up, load travel timer with TRAVEL_CYCLES-1, go to MOVING.
- MOVING:
  - Travel timer decrements each cycle.
  - When it reads 0: cur_floor ±1 per dir_up.
  - If pending[new floor]: go to DOOR on that same edge.
  - Else reload the timer and keep moving.
  - One floor therefore takes exactly TRAVEL_CYCLES cycles.
  - Direction is never reversed mid-motion. Requests latched behind the car are served after the current sweep.
- DOOR:
  - door_open=1; door timer is loaded with DOOR_CYCLES-1 on entry.
  - Timer decrements; it is reloaded while door_hold=1 or call_req[cur_floor]=1.
  - At 0: go to IDLE.
  - Minimum dwell is DOOR_CYCLES cycles.
- Boundaries:
  - cur_floor never below 0 or above NUM_FLOORS-1.
  - At floor 0, dir_up is forced to 1 on leaving DOOR. At the top floor it is forced to 0.
  - Requests for out-of-range floors cannot exist (bit vector).
- Simultaneous events: a new call for the floor being arrived at on the arrival edge counts as served (door opens, bit stays clear).
- Reset mid-motion: immediate return to the reset state. No position is preserved.

Optional Feature:
- Macro LIFT_EMERG_EN.
- When defined:
  - Adds input emerg_stop (1 bit).
  - While emerg_stop=1 in MOVING, the current floor segment completes. The car then enters DOOR at the next floor regardless of pending.
  - All pending bits are cleared and new calls are ignored.
  - DOOR is held while emerg_stop=1. Normal operation resumes via IDLE after deassertion plus the dwell.
- When undefined: the port is absent and the behaviour is exactly as above.

Test Plan:
- Reset: release reset at cur_floor=0 with no calls → IDLE, door_open=0, moving=0 indefinitely; reassert reset while moving → all outputs return to reset values asynchronously.
- Single call: one-cycle call_req[3] at floor 0 (defaults) → moving=1 two edges later; cur_floor steps 1,2,3 every 4 cycles; door_open=1 on the edge cur_floor=3; held 6 cycles; pending[3]=0.
- Sweep order: at floor 2 moving up, calls for floors 1 and 5 → stops at 5 first, then reverses and stops at 1.
- Door hold: door_hold=1 for 10 cycles during DOOR → door_open stays 1 for 10+6 cycles; a call at the current floor likewise extends the dwell and is not latched.
- Top boundary: NUM_FLOORS=4, car at floor 3, call floor 0 → dir_up=0; cur_floor 2,1,0; never exceeds 3.
- LIFT_EMERG_EN: assert emerg_stop mid-segment with pending {6,7} → car stops at the next floor with the door open and pending=0; resumes IDLE after release plus 6 cycles.
